pwm_fade_sequencer: RTL and testbench

Command-driven controller sitting in front of `pwm_peripheral`: it owns the four enable-register buses and the shared `pwm_duty_cycle` byte that feed the PWM block. On each accepted command it loads the channel enables, then ramps the duty cycle from its current value to a target in programmable steps at a prescaled tick rate. It signals completion with a one-cycle `done` pulse. It replaces static register writes when LEDs/motors on `uo_out`/`uio_out` need soft fades.

---
 rtl/pwm_fade_sequencer_if.sv | 27 ++
 rtl/pwm_fade_sequencer.sv | 148 ++++++++++++++
 tb/tb_pwm_fade_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_fade_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pwm_fade_sequencer_if                                            |
// | Brief   : Command handshake bundle between a fade requester and sequencer. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
interface pwm_fade_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_target;
  logic [3:0]  cmd_step;
  logic [7:0]  cmd_hold;
  logic [15:0] cmd_out_en;
  logic [15:0] cmd_pwm_en;
  logic        abort;

  modport master (
    output cmd_valid, cmd_target, cmd_step, cmd_hold, cmd_out_en, cmd_pwm_en, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_target, cmd_step, cmd_hold, cmd_out_en, cmd_pwm_en, abort,
    output cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/pwm_fade_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pwm_fade_sequencer                                               |
// | Brief   : Loads PWM channel enables and ramps the shared duty byte toward  |
// |           a target in prescaled steps. Define PWM_FADE_GAMMA_EN to apply a |
// |           squared gamma curve to the duty presented to pwm_peripheral.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module pwm_fade_sequencer #(
  parameter int TICK_DIV = 3334
) (
  input  logic                       clk,
  input  logic                       rst,
  pwm_fade_sequencer_if.slave        cmd,
  output logic [7:0]                 en_reg_out_7_0,
  output logic [7:0]                 en_reg_out_15_8,
  output logic [7:0]                 en_reg_pwm_7_0,
  output logic [7:0]                 en_reg_pwm_15_8,
  output logic [7:0]                 pwm_duty_cycle,
  output logic                       busy,
  output logic                       done
);

  localparam logic [11:0] PRESC_LAST = 12'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  duty;
  logic [7:0]  target;
  logic [3:0]  step;
  logic [7:0]  hold;
  logic [7:0]  hold_cnt;
  logic [11:0] presc;
  logic        ready;

  logic        tick;
  logic [8:0]  up_sum;
  logic [8:0]  dn_diff;
  logic [7:0]  duty_next;

  assign tick          = (presc == PRESC_LAST);
  assign cmd.cmd_ready = ready;

  // Nine-bit sums let the clamp catch both overshoot and wrap below zero.
  always_comb begin
    up_sum    = {1'b0, duty} + {5'd0, step};
    dn_diff   = {1'b0, duty} - {5'd0, step};
    duty_next = target;
    if (duty < target) begin
      if (up_sum < {1'b0, target}) begin
        duty_next = up_sum[7:0];
      end
    end else if (!dn_diff[8] && (dn_diff[7:0] > target)) begin
      duty_next = dn_diff[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      duty            <= 8'd0;
      target          <= 8'd0;
      step            <= 4'd1;
      hold            <= 8'd0;
      hold_cnt        <= 8'd0;
      presc           <= 12'd0;
      en_reg_out_7_0  <= 8'd0;
      en_reg_out_15_8 <= 8'd0;
      en_reg_pwm_7_0  <= 8'd0;
      en_reg_pwm_15_8 <= 8'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      ready           <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            target          <= cmd.cmd_target;
            step            <= (cmd.cmd_step == 4'd0) ? 4'd1 : cmd.cmd_step;
            hold            <= cmd.cmd_hold;
            en_reg_out_7_0  <= cmd.cmd_out_en[7:0];
            en_reg_out_15_8 <= cmd.cmd_out_en[15:8];
            en_reg_pwm_7_0  <= cmd.cmd_pwm_en[7:0];
            en_reg_pwm_15_8 <= cmd.cmd_pwm_en[15:8];
            presc           <= 12'd0;
            hold_cnt        <= 8'd0;
            busy            <= 1'b1;
            ready           <= 1'b0;
            state           <= S_RAMP;
          end
        end
        S_RAMP: begin
          if (cmd.abort) begin
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= S_IDLE;
          end else if (duty == target) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (tick) begin
            presc <= 12'd0;
            if (hold_cnt == hold) begin
              duty     <= duty_next;
              hold_cnt <= 8'd0;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end else begin
            presc <= presc + 12'd1;
          end
        end
        S_DONE: begin
          ready <= 1'b1;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PWM_FADE_GAMMA_EN
  logic [15:0] d_plus1;
  logic [15:0] gamma_sq;

  // The 16-bit product wraps to zero at d=255 so the minus-one lands on 0xFFFF.
  always_comb begin
    d_plus1  = {8'd0, duty} + 16'd1;
    gamma_sq = (d_plus1 * d_plus1) - 16'd1;
  end

  assign pwm_duty_cycle = gamma_sq[15:8];
`else
  assign pwm_duty_cycle = duty;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_fade_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_pwm_fade_sequencer                                            |
// | Brief   : Scoreboard bench; an event-level fade model predicts every output |
// |           change, a monitor pops and compares. Honours PWM_FADE_GAMMA_EN.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_pwm_fade_sequencer;
  localparam int TICK_DIV = 4;
  localparam int K_EN = 0, K_BUSY = 1, K_READY = 2, K_DUTY = 3, K_DONE = 4;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  ev_t  expq[$];
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;

  int          m_duty = 0;
  logic [31:0] m_en = 32'd0;
  int          m_pwm = 0;

  logic [7:0] eo0, eo1, ep0, ep1, pwm;
  logic       busy, done;

  pwm_fade_sequencer_if cmd_if ();

  pwm_fade_sequencer #(.TICK_DIV(TICK_DIV)) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd             (cmd_if),
    .en_reg_out_7_0  (eo0),
    .en_reg_out_15_8 (eo1),
    .en_reg_pwm_7_0  (ep0),
    .en_reg_pwm_15_8 (ep1),
    .pwm_duty_cycle  (pwm),
    .busy            (busy),
    .done            (done)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gamma(int d);
`ifdef PWM_FADE_GAMMA_EN
    return (((d + 1) * (d + 1)) - 1) >> 8;
`else
    return d;
`endif
  endfunction

  task automatic push(int c, int k, int v);
    expq.push_back('{cyc: c, kind: k, val: v});
  endtask

  task automatic chk(string nm, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic check_ev(int k, int v);
    ev_t e;
    n_cmp++;
    if (expq.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d got %0d expected none", k, cyc, v);
    end else begin
      e = expq.pop_front();
      if (e.kind != k || e.cyc != cyc || e.val != v) begin
        n_err++;
        $display("FAIL event kind/cyc/val got %0d/%0d/%0d expected %0d/%0d/%0d",
                 k, cyc, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  // Predicts every observable change for one accepted command from the fade rules.
  task automatic model_cmd(int a, int t, int s, int h, logic [31:0] en, int ab,
                           output int end_edge);
    int p, se, d, last, k, e;
    p    = TICK_DIV * (h + 1);
    se   = (s == 0) ? 1 : s;
    d    = m_duty;
    last = a;
    k    = 0;
    if (en != m_en) push(a, K_EN, en);
    m_en = en;
    push(a, K_BUSY, 1);
    push(a, K_READY, 0);
    while (d != t) begin
      k++;
      e = a + k * p;
      if (ab != 0 && e >= ab) break;
      if (d < t) d = (d + se > t) ? t : d + se;
      else       d = (d - se < t) ? t : d - se;
      if (gamma(d) != m_pwm) begin
        m_pwm = gamma(d);
        push(e, K_DUTY, m_pwm);
      end
      last = e;
    end
    m_duty = d;
    if (ab != 0 && (d != t || ab <= last + 1)) begin
      push(ab, K_BUSY, 0);
      push(ab, K_READY, 1);
      end_edge = ab;
    end else begin
      push(last + 1, K_BUSY, 0);
      push(last + 1, K_DONE, 1);
      push(last + 2, K_READY, 1);
      end_edge = last + 2;
    end
  endtask

  // Called at a negedge; returns at the negedge after the command has fully retired.
  task automatic issue(int t, int s, int h, logic [15:0] oe, logic [15:0] pe,
                       bit abort_with_valid, int ab_rel, bit poke);
    bit ok;
    int a, ab, fin, end_edge;
    ok = 1'b0;
    ab = 0;
    cmd_if.cmd_target = t[7:0];
    cmd_if.cmd_step   = s[3:0];
    cmd_if.cmd_hold   = h[7:0];
    cmd_if.cmd_out_en = oe;
    cmd_if.cmd_pwm_en = pe;
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.abort      = abort_with_valid;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (cmd_if.cmd_ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got cmd_ready 0 expected 1 within 200 cycles");
      cmd_if.cmd_valid = 1'b0;
      cmd_if.abort     = 1'b0;
      return;
    end
    a = cyc + 1;
    if (ab_rel > 0) ab = a + ab_rel;
    model_cmd(a, t, s, h, {oe, pe}, ab, end_edge);
    fin = (ab > end_edge) ? ab : end_edge;
    @(negedge clk);
    while (cyc < fin) begin
      cmd_if.cmd_valid = poke && (cyc >= a + 2) && (cyc < a + 5);
      if (poke) begin
        cmd_if.cmd_target = 8'd9;
        cmd_if.cmd_out_en = ~oe;
      end
      cmd_if.abort = (ab != 0) && (cyc == ab - 1);
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    cmd_if.abort     = 1'b0;
  endtask

  task automatic mon_restart();
    m_duty = 0;
    m_en   = 32'd0;
    m_pwm  = 0;
    mon_en = 1'b1;
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_en"},    {eo1, eo0, ep1, ep0}, 0);
    chk({tag, "_pwm"},   {24'd0, pwm}, 0);
    chk({tag, "_busy"},  {31'd0, busy}, 0);
    chk({tag, "_done"},  {31'd0, done}, 0);
    chk({tag, "_ready"}, {31'd0, cmd_if.cmd_ready}, 1);
  endtask

  // Monitor: every change of an output (or a high done) must match the queue head.
  logic [31:0] p_en;
  logic        p_busy, p_ready;
  logic [7:0]  p_pwm;
  initial begin
    p_en = 32'd0; p_busy = 1'b0; p_ready = 1'b1; p_pwm = 8'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!mon_en) begin
        p_en = 32'd0; p_busy = 1'b0; p_ready = 1'b1; p_pwm = 8'd0;
      end else begin
        if ({eo1, eo0, ep1, ep0} !== p_en) begin
          check_ev(K_EN, {eo1, eo0, ep1, ep0});
          p_en = {eo1, eo0, ep1, ep0};
        end
        if (busy !== p_busy) begin
          check_ev(K_BUSY, {31'd0, busy});
          p_busy = busy;
        end
        if (cmd_if.cmd_ready !== p_ready) begin
          check_ev(K_READY, {31'd0, cmd_if.cmd_ready});
          p_ready = cmd_if.cmd_ready;
        end
        if (pwm !== p_pwm) begin
          check_ev(K_DUTY, {24'd0, pwm});
          p_pwm = pwm;
        end
        if (done !== 1'b0) check_ev(K_DONE, {31'd0, done});
      end
    end
  end

  initial begin
    int a, ee;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.abort      = 1'b0;
    cmd_if.cmd_target = 8'd0;
    cmd_if.cmd_step   = 4'd0;
    cmd_if.cmd_hold   = 8'd0;
    cmd_if.cmd_out_en = 16'd0;
    cmd_if.cmd_pwm_en = 16'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    mon_restart();

    issue(8, 4, 0, 16'h00FF, 16'h000F, 1'b0, 0, 1'b0);     // up-ramp
    issue(1, 5, 1, 16'hA5A5, 16'h5A5A, 1'b0, 0, 1'b0);     // down with clamp and hold
    issue(3, 0, 0, 16'h1234, 16'h8001, 1'b0, 0, 1'b0);     // step 0 acts as 1
    issue(3, 7, 2, 16'h1234, 16'h8001, 1'b0, 0, 1'b0);     // zero-length
    issue(0, 15, 0, 16'h0001, 16'h0002, 1'b0, 0, 1'b0);
    issue(200, 1, 0, 16'hFFFF, 16'h00F0, 1'b0, 37 * TICK_DIV + 1, 1'b1);  // abort at 37
    issue(40, 3, 0, 16'h0F0F, 16'hF0F0, 1'b1, 0, 1'b0);    // abort with valid in IDLE
    issue(128, 15, 0, 16'h0003, 16'h0003, 1'b0, 0, 1'b0);
    issue(255, 15, 0, 16'h0003, 16'h0003, 1'b0, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int t, s, h, abr;
      t   = $urandom_range(0, 255);
      s   = $urandom_range(0, 15);
      h   = $urandom_range(0, 2);
      abr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0;
      issue(t, s, h, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), abr, 1'b0);
    end

    // Reset in the middle of a ramp.
    cmd_if.cmd_target = 8'd250;
    cmd_if.cmd_step   = 4'd1;
    cmd_if.cmd_hold   = 8'd0;
    cmd_if.cmd_out_en = 16'hBEEF;
    cmd_if.cmd_pwm_en = 16'hCAFE;
    cmd_if.cmd_valid  = 1'b1;
    chk("ready_before_reset_ramp", {31'd0, cmd_if.cmd_ready}, 1);
    a = cyc + 1;
    model_cmd(a, 250, 1, 0, 32'hBEEFCAFE, 0, ee);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    while (cyc < a + 20) @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("mid_ramp_reset");
    expq.delete();
    rst = 1'b0;
    mon_restart();
    issue(2, 1, 0, 16'h0100, 16'h0200, 1'b0, 0, 1'b0);

    repeat (4) @(negedge clk);
    chk("scoreboard_left", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
